// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake for the bit-serial adder controller: request, operands,
// status and the registered result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: walks an external 1-bit full adder through WIDTH bit
// pairs LSB first, collects the sum bits and final carry, then pulses done.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_ctrl_if.slave    bus,
  output logic                fa_a,
  output logic                fa_b,
  output logic                fa_cin,
  input  logic                fa_sum,
  input  logic                fa_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             running;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.op_a;
          b_sh_d  = bus.op_b;
          carry_d = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
        sum_sh_d = (sum_sh_q >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = sum_sh_d;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The adder only sees live operands while a run is in progress.
  assign running = (state_q == RUN);
  assign fa_a    = running & a_sh_q[0];
  assign fa_b    = running & b_sh_q[0];
  assign fa_cin  = running & carry_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full adder on the fa_* side.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  int   total;
  int   bad;
  int   n;
  int   nb;
  logic [W-1:0] last_sum;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_sum (fa_sum),
    .fa_cout(fa_cout)
  );

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then latency, busy length, result, done pulse width and fa_* idle levels.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec, input string tag);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, "_fa_bit0"}, {29'd0, fa_a, fa_b, fa_cin}, {29'd0, a[0], b[0], c});
    chk({tag, "_sum_hold"}, {24'd0, bus.sum}, {24'd0, last_sum});
    n  = 0;
    nb = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) nb++;
      step();
      n++;
    end
    if (bus.busy) nb++;
    chk({tag, "_latency"}, n, W);
    chk({tag, "_busy_len"}, nb, W + 1);
    chk({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({tag, "_fa_idle"}, {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    step();
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, bus.busy}, 32'd0);
    last_sum = es;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    last_sum  = '0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.cin   = 1'($urandom);

    // Reset held with random request inputs
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_sum", {24'd0, bus.sum}, 32'd0);
      chk("rst_cout", {31'd0, bus.cout}, 32'd0);
      chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;

    do_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "basic");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap");
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "cin");

    // start held high: operand change mid-run ignored, back-to-back spacing WIDTH+2
    bus.op_a  = 8'h10;
    bus.op_b  = 8'h20;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.op_a = 8'h01;
    bus.op_b = 8'h01;
    n = 0;
    while (!bus.done && n < 20) begin
      step();
      n++;
    end
    chk("held_lat1", n, W);
    chk("held_sum1", {24'd0, bus.sum}, 32'h30);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.done && n < 30);
    chk("held_gap", n, W + 2);
    chk("held_sum2", {24'd0, bus.sum}, 32'h02);
    chk("held_cout2", {31'd0, bus.cout}, 32'd0);
    bus.start = 1'b0;
    step();
    step();
    chk("held_idle", {31'd0, bus.busy}, 32'd0);

    // Reset asserted in the 4th RUN cycle
    bus.op_a  = 8'h12;
    bus.op_b  = 8'h34;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_sum", {24'd0, bus.sum}, 32'd0);
    chk("mid_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) n++;
      step();
    end
    chk("mid_no_done", n, 0);
    rst_n    = 1'b1;
    last_sum = '0;
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
